// File: rtl/draw_player_if.sv
// vga_if: one pixel of the VGA stream between pipeline stages.
//   vcount, hcount : 11-bit beam position
//   vsync, hsync   : sync pulses
//   vblnk, hblnk   : blanking flags
//   rgb            : 12-bit colour, 4 bits per channel
// Modport "in" is the consumer view and modport "out" is the producer view.
// The stream carries one pixel every clock. It has no valid/ready pair and
// no backpressure: a stage must accept a pixel every cycle.
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        vblnk;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
  modport out (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_player.sv
// draw_player: paints the player sprite, a solid rectangle, over the
// background stream. It also owns the player's position: walking with edge
// clamping, plus a per-frame jump/gravity state machine.
// Ports:
//   clk, rst         : pixel clock; synchronous active-high reset
//   btn_left/right   : asynchronous walk buttons
//   btn_jump         : asynchronous jump button
//   vga_in           : background stream
//   vga_out          : the same stream, one cycle later, with the sprite overlaid
//   xpos, ypos       : sprite left column and bottom row
//   airborne         : 1 while the vertical FSM is in AIR (this exposes the FSM state)
module draw_player #(
  parameter int          WIDTH    = 32,
  parameter int          HEIGHT   = 48,
  parameter int          X_INIT   = 100,
  parameter int          GROUND_Y = 500,
  parameter int          SPEED    = 2,
  parameter int          JUMP_V0  = 12,
  parameter int          GRAVITY  = 1,
  parameter logic [11:0] COLOR    = 12'hF80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  vga_if.in           vga_in,
  vga_if.out          vga_out,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic        airborne
);

  localparam int HOR_PIXELS = 800;

  localparam logic [0:0] GROUND = 1'b0;
  localparam logic [0:0] AIR    = 1'b1;

  localparam logic signed [11:0] SPEED_S  = 12'(SPEED);
  localparam logic signed [11:0] X_MAX    = 12'(HOR_PIXELS - WIDTH);
  localparam logic signed [11:0] GROUND_S = 12'(GROUND_Y);

  // Two-flop synchronisers. Bit 1 is the value that is safe to use.
  logic [1:0] l_sync, r_sync, j_sync;
  logic       l, r, j;

  assign l = l_sync[1];
  assign r = r_sync[1];
  assign j = j_sync[1];

  // The frame tick is the rising edge of vblnk. Position updates happen only
  // here, so xpos and ypos stay constant across the visible region.
  logic vblnk_d;
  logic tick;

  assign tick = vga_in.vblnk & ~vblnk_d;

  logic [0:0]        state, state_nxt;
  logic signed [7:0] vel, vel_nxt;
  logic [10:0]       x_nxt, y_nxt;

  // Horizontal motion. The arithmetic is 12-bit signed, so stepping left
  // from a small x goes negative instead of wrapping.
  logic signed [11:0] x_s, x_dec, x_inc;

  assign x_s   = {1'b0, xpos};
  assign x_dec = x_s - SPEED_S;
  assign x_inc = x_s + SPEED_S;

  always_comb begin
    x_nxt = xpos;
    if (l & ~r) begin
      x_nxt = (x_dec < 12'sd0) ? 11'd0 : x_dec[10:0];
    end else if (r & ~l) begin
      x_nxt = (x_inc > X_MAX) ? X_MAX[10:0] : x_inc[10:0];
    end
  end

  // Vertical FSM. A positive vel means upward motion, and the screen y
  // coordinate grows downward, so the next row is ypos - vel.
  logic signed [11:0] ny;

  assign ny = {1'b0, ypos} - {{4{vel[7]}}, vel};

  always_comb begin
    state_nxt = state;
    y_nxt     = ypos;
    vel_nxt   = vel;
    case (state)
      GROUND: begin
        if (j) begin
          y_nxt     = 11'(GROUND_Y - JUMP_V0);
          vel_nxt   = 8'(JUMP_V0 - GRAVITY);
          state_nxt = AIR;
        end
      end
      AIR: begin
        if (ny >= GROUND_S) begin
          y_nxt     = 11'(GROUND_Y);
          vel_nxt   = 8'sd0;
          state_nxt = GROUND;
        end else begin
          y_nxt   = ny[10:0];
          vel_nxt = vel - 8'(GRAVITY);
        end
      end
      default: begin
        state_nxt = GROUND;
      end
    endcase
  end

  // Hit test. The extents are computed in 12 bits so that xpos + WIDTH and
  // ypos - HEIGHT cannot overflow. The vertical compare is signed because
  // ypos - HEIGHT can be negative.
  logic [11:0]        x_end;
  logic signed [11:0] y_top, v_s;
  logic               hit;
  logic [11:0]        rgb_nxt;

  assign x_end = {1'b0, xpos} + 12'(WIDTH);
  assign y_top = {1'b0, ypos} - 12'(HEIGHT);
  assign v_s   = {1'b0, vga_in.vcount};

  assign hit = ~vga_in.vblnk & ~vga_in.hblnk &
               (vga_in.hcount >= xpos) &
               ({1'b0, vga_in.hcount} < x_end) &
               (v_s > y_top) &
               (vga_in.vcount <= ypos);

  assign rgb_nxt = hit ? COLOR : vga_in.rgb;

  always_ff @(posedge clk) begin
    if (rst) begin
      l_sync  <= 2'b00;
      r_sync  <= 2'b00;
      j_sync  <= 2'b00;
      vblnk_d <= 1'b0;
      xpos    <= 11'(X_INIT);
      ypos    <= 11'(GROUND_Y);
      vel     <= 8'sd0;
      state   <= GROUND;
    end else begin
      l_sync  <= {l_sync[0], btn_left};
      r_sync  <= {r_sync[0], btn_right};
      j_sync  <= {j_sync[0], btn_jump};
      vblnk_d <= vga_in.vblnk;
      if (tick) begin
        xpos  <= x_nxt;
        ypos  <= y_nxt;
        vel   <= vel_nxt;
        state <= state_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.vcount <= 11'd0;
      vga_out.hcount <= 11'd0;
      vga_out.vsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.rgb    <= 12'd0;
    end else begin
      vga_out.vcount <= vga_in.vcount;
      vga_out.hcount <= vga_in.hcount;
      vga_out.vsync  <= vga_in.vsync;
      vga_out.vblnk  <= vga_in.vblnk;
      vga_out.hsync  <= vga_in.hsync;
      vga_out.hblnk  <= vga_in.hblnk;
      vga_out.rgb    <= rgb_nxt;
    end
  end

  assign airborne = (state == AIR);

endmodule

// File: tb/tb_draw_player.sv
// tb_draw_player: directed test of draw_player.
// The bench drives a compressed "frame". Each frame has a few probe pixels
// around the sprite edges, followed by a short vertical blank. A physics
// model predicts the output stream and the position on every cycle. Literal
// checks pin the reset state, the clamps and the jump trajectory.
// Buttons change only at the start of a frame's visible part. That is well
// ahead of the tick, so the model can read the raw button levels at the tick.
module tb_draw_player;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_left, btn_right, btn_jump;
  logic [10:0] xpos, ypos;
  logic        airborne;

  vga_if vin ();
  vga_if vout ();

  draw_player dut (
    .clk       (clk),
    .rst       (rst),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_jump  (btn_jump),
    .vga_in    (vin),
    .vga_out   (vout),
    .xpos      (xpos),
    .ypos      (ypos),
    .airborne  (airborne)
  );

  // ---------------- clock / timeout ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- counters / checks ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Bit layout of each expected entry:
  // {vcount, hcount, vsync, vblnk, hsync, hblnk, rgb, xpos, ypos, airborne}
  localparam int W = 61;
  logic [W-1:0] exp_q[$];

  int mx = 100, my = 500, mvel = 0;
  bit mair = 0, mvb_prev = 0;

  initial begin
    int h, v, ny;
    bit hit, tick;
    logic [11:0] e_rgb;
    forever begin
      @(posedge clk);
      if (rst) begin
        mx = 100; my = 500; mvel = 0; mair = 0; mvb_prev = 0;
        exp_q.push_back({38'd0, 11'd100, 11'd500, 1'b0});
      end else begin
        h = int'(vin.hcount);
        v = int'(vin.vcount);
        hit = !vin.vblnk && !vin.hblnk && h >= mx && h < mx + 32 &&
              v > my - 48 && v <= my;
        e_rgb = hit ? 12'hF80 : vin.rgb;
        tick = vin.vblnk && !mvb_prev;
        mvb_prev = vin.vblnk;
        if (tick) begin
          if (btn_left && !btn_right) mx = (mx - 2 < 0) ? 0 : mx - 2;
          else if (btn_right && !btn_left) mx = (mx + 2 > 768) ? 768 : mx + 2;
          if (!mair) begin
            if (btn_jump) begin my = 488; mvel = 11; mair = 1; end
          end else begin
            ny = my - mvel;
            if (ny >= 500) begin my = 500; mvel = 0; mair = 0; end
            else begin my = ny; mvel = mvel - 1; end
          end
        end
        exp_q.push_back({vin.vcount, vin.hcount, vin.vsync, vin.vblnk, vin.hsync,
                         vin.hblnk, e_rgb, 11'(mx), 11'(my), mair});
      end
    end
  end

  // ---------------- scoreboard compare (every cycle) ----------------
  initial begin
    logic [W-1:0] e, got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {vout.vcount, vout.hcount, vout.vsync, vout.vblnk, vout.hsync,
               vout.hblnk, vout.rgb, xpos, ypos, airborne};
        chk("stream_timing", 32'(got[60:35]), 32'(e[60:35]));
        chk("stream_rgb", 32'(got[34:23]), 32'(e[34:23]));
        chk("position", 32'(got[22:0]), 32'(e[22:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_px(input int h, input int v, input logic hb, input logic vb,
                          input logic vs, input logic [11:0] bg);
    @(negedge clk);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = hb & 1'($urandom_range(0, 1));
    vin.vsync  = vs;
    vin.rgb    = bg;
  endtask

  // The pixel driven here appears on vga_out one edge later.
  task automatic probe(input int h, input int v, input logic [11:0] bg,
                       input logic [11:0] exp, input string name);
    drive_px(h, v, 1'b0, 1'b0, 1'b0, bg);
    @(negedge clk);
    chk(name, 32'(vout.rgb), 32'(exp));
  endtask

  task automatic active_part();
    int hs[4];
    int vs[4];
    hs = '{mx - 1, mx, mx + 31, mx + 32};
    vs = '{my - 48, my - 47, my, my + 1};
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++)
        drive_px(hs[i], vs[k], 1'b0, 1'b0, 1'b0, 12'($urandom));
    drive_px(mx, my, 1'b1, 1'b0, 1'b0, 12'($urandom));
    drive_px(mx + 5, my - 5, 1'b1, 1'b0, 1'b0, 12'($urandom));
  endtask

  // Vertical blank of 4 cycles. The tick is on the first cycle, and a reset
  // can optionally be applied on that same cycle.
  task automatic blank_part(input bit rst_at_tick);
    drive_px(mx, my, 1'b1, 1'b1, 1'b0, 12'($urandom));
    if (rst_at_tick) begin
      rst = 1'b1;
      @(negedge clk);
      chk("rst_midair_ypos", 32'(ypos), 32'd500);
      chk("rst_midair_airborne", 32'(airborne), 32'd0);
      chk("rst_midair_xpos", 32'(xpos), 32'd100);
      rst = 1'b0;
    end
    drive_px(mx, my, 1'b1, 1'b1, 1'b1, 12'($urandom));
    drive_px(mx, my, 1'b0, 1'b1, 1'b1, 12'($urandom));
    drive_px(mx, my, 1'b1, 1'b1, 1'b0, 12'($urandom));
  endtask

  task automatic frame();
    active_part();
    blank_part(1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    vin.hcount = '0; vin.vcount = '0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.rgb = '0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  int traj[25] = '{488, 477, 467, 458, 450, 443, 437, 432, 428, 425, 423, 422, 422,
                   423, 425, 428, 432, 437, 443, 450, 458, 467, 477, 488, 500};

  initial begin
    int ymin;
    rst = 1'b1;
    btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
    vin.hcount = '0; vin.vcount = '0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.rgb = '0;

    // Reset and idle.
    do_reset();
    @(negedge clk);
    chk("reset_vga_out_rgb", 32'(vout.rgb), 32'd0);
    repeat (2) frame();
    chk("idle_xpos", 32'(xpos), 32'd100);
    chk("idle_ypos", 32'(ypos), 32'd500);
    probe(100, 453, 12'h0A5, 12'hF80, "px_100_453");
    probe(100, 452, 12'h0A5, 12'h0A5, "px_100_452");
    probe(132, 500, 12'h3C7, 12'h3C7, "px_132_500");
    probe(131, 500, 12'h3C7, 12'hF80, "px_131_500");

    // Walk and clamp.
    btn_right = 1'b1;
    repeat (10) frame();
    btn_right = 1'b0;
    chk("walk_right_10", 32'(xpos), 32'd120);
    btn_left = 1'b1;
    repeat (70) frame();
    chk("walk_left_clamp", 32'(xpos), 32'd0);
    repeat (3) frame();
    btn_left = 1'b0;
    chk("walk_left_hold0", 32'(xpos), 32'd0);
    btn_right = 1'b1;
    repeat (383) frame();
    chk("walk_right_766", 32'(xpos), 32'd766);
    frame();
    chk("walk_right_768", 32'(xpos), 32'd768);
    repeat (3) frame();
    btn_right = 1'b0;
    chk("walk_right_hold768", 32'(xpos), 32'd768);

    // Both buttons held: no horizontal motion.
    btn_left = 1'b1; btn_right = 1'b1;
    repeat (5) frame();
    btn_left = 1'b0; btn_right = 1'b0;
    chk("both_dirs_hold", 32'(xpos), 32'd768);

    // Jump trajectory, with a second press mid-air on tick 5.
    do_reset();
    frame();
    ymin = 1000;
    for (int k = 1; k <= 25; k++) begin
      if (k == 1 || k == 5) btn_jump = 1'b1;
      frame();
      btn_jump = 1'b0;
      chk($sformatf("traj_ypos_t%0d", k), 32'(ypos), 32'(traj[k-1]));
      chk($sformatf("traj_air_t%0d", k), 32'(airborne), (k < 25) ? 32'd1 : 32'd0);
      if (int'(ypos) < ymin) ymin = int'(ypos);
    end
    chk("traj_min", 32'(ymin), 32'd422);
    frame();
    chk("ground_after_land", 32'(ypos), 32'd500);

    // Jump held continuously.
    btn_jump = 1'b1;
    repeat (25) frame();
    chk("held_land_ypos", 32'(ypos), 32'd500);
    chk("held_land_air", 32'(airborne), 32'd0);
    frame();
    chk("held_rejump_ypos", 32'(ypos), 32'd488);
    btn_jump = 1'b0;

    // Reset applied mid-air on tick 6.
    do_reset();
    frame();
    btn_jump = 1'b1;
    frame();
    btn_jump = 1'b0;
    repeat (4) frame();
    chk("pre_rst_ypos_t5", 32'(ypos), 32'd450);
    active_part();
    blank_part(1'b1);
    repeat (2) frame();
    chk("post_rst_ypos", 32'(ypos), 32'd500);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
